// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared types and constants for the three-way round-robin mux arbiter.
//   NUM_REQ        : number of requesters (fixed at 3)
//   state_e        : arbiter FSM states (IDLE, BUSY)
//   sel_t / SEL_*  : encodings driven on the registered select output
//   rr_next        : advance a requester index round-robin (0 -> 1 -> 2 -> 0)
//   onehot_to_idx  : requester index of a one-hot grant vector
//   grant_to_sel   : select encoding that corresponds to a grant vector
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IDLE = 2'b00;
    localparam sel_t SEL_REQ0 = 2'b01;
    localparam sel_t SEL_REQ1 = 2'b10;
    localparam sel_t SEL_REQ2 = 2'b11;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Caller guarantees at most one bit set; zero maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[2]) begin
            idx = 2'd2;
        end else if (oh[1]) begin
            idx = 2'd1;
        end
        return idx;
    endfunction

    function automatic sel_t grant_to_sel(input logic [NUM_REQ-1:0] grant);
        sel_t sel;
        case (grant)
            3'b001:  sel = SEL_REQ0;
            3'b010:  sel = SEL_REQ1;
            3'b100:  sel = SEL_REQ2;
            default: sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_arbiter_if
// Bundle between the requesters and the arbiter.
//   req       : request per requester (bit i = requester i)
//   din       : data bit per requester, routed when that requester is granted
//   lock      : per-requester lock, only when MUX_ARBITER_LOCK_EN is defined
//   grant     : registered one-hot grant (all-zero when idle)
//   select    : registered mux select (00 idle, 01/10/11 requester 0/1/2)
//   mux_out   : registered data of the granted requester
//   out_valid : mux_out carries granted data
// Modports: master = requester side, slave = arbiter side.
// Optional feature macro: MUX_ARBITER_LOCK_EN.
// -----------------------------------------------------------------------------
interface mux_arbiter_if;
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] din;
`ifdef MUX_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0] lock;
`endif
    logic [NUM_REQ-1:0] grant;
    sel_t               select;
    logic               mux_out;
    logic               out_valid;

    modport master (
`ifdef MUX_ARBITER_LOCK_EN
        output lock,
`endif
        output req,
        output din,
        input  grant,
        input  select,
        input  mux_out,
        input  out_valid
    );

    modport slave (
`ifdef MUX_ARBITER_LOCK_EN
        input  lock,
`endif
        input  req,
        input  din,
        output grant,
        output select,
        output mux_out,
        output out_valid
    );

endinterface

// File: rtl/mux_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: searches req starting at
// (last_winner + 1) mod 3 and returns the first requester found.
//   req         : candidate requests
//   last_winner : index of the most recent winner (0..2)
//   gnt         : one-hot pick (zero when nothing found)
//   found       : a requester was picked
// -----------------------------------------------------------------------------
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_winner,
    output logic [NUM_REQ-1:0] gnt,
    output logic               found
);

    logic [1:0] cand;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = rr_next(last_winner);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                found     = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
// Three-requester round-robin arbiter with a registered one-bit data mux.
// A granted requester keeps the grant while its req stays high; once it has
// held for MAX_HOLD cycles and another requester is pending, the grant moves
// straight to the next round-robin requester without an idle cycle.
// Ports:
//   clock    : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mux_arbiter_if.slave (req, din, [lock], grant, select,
//              mux_out, out_valid)
// Parameter:
//   MAX_HOLD : max consecutive grant cycles while others wait (1..15)
// Optional feature macro: MUX_ARBITER_LOCK_EN -- a high lock[g] together with
// req[g] on the granted requester suppresses the MAX_HOLD preemption.
// -----------------------------------------------------------------------------
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic          clock,
    input logic          reset_n,
    mux_arbiter_if.slave bus
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    sel_t               sel_q, sel_d;
    logic [3:0]         hold_q, hold_d;
    logic [1:0]         last_q, last_d;
    logic               mux_q, mux_d;
    logic               valid_q, valid_d;

    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_found;
    logic               held;
    logic               locked;

    // The current owner is never a candidate; in IDLE grant_q is zero so all
    // requests are candidates. last_q always equals the current owner in BUSY.
    assign req_masked = bus.req & ~grant_q;
    assign held       = |(bus.req & grant_q);

`ifdef MUX_ARBITER_LOCK_EN
    assign locked = |(bus.lock & bus.req & grant_q);
`else
    assign locked = 1'b0;
`endif

    rr_pick u_rr_pick (
        .req         (req_masked),
        .last_winner (last_q),
        .gnt         (pick_gnt),
        .found       (pick_found)
    );

    // Grant FSM
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    hold_d  = '0;
                    last_d  = onehot_to_idx(pick_gnt);
                end
            end
            BUSY: begin
                if (!held) begin
                    // Owner released: hand over or fall back to idle.
                    if (pick_found) begin
                        grant_d = pick_gnt;
                        hold_d  = '0;
                        last_d  = onehot_to_idx(pick_gnt);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX) begin
                    // Hold budget spent; counter stays saturated if nobody waits.
                    if (pick_found && !locked) begin
                        grant_d = pick_gnt;
                        hold_d  = '0;
                        last_d  = onehot_to_idx(pick_gnt);
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase

        sel_d = grant_to_sel(grant_d);
    end

    // Data path: routes the requester that owned the grant during this cycle.
    always_comb begin
        mux_d   = mux_q;
        valid_d = 1'b0;
        if (|grant_q) begin
            mux_d   = bus.din[onehot_to_idx(grant_q)];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= SEL_IDLE;
            hold_q  <= '0;
            last_q  <= 2'd2;
            mux_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            mux_q   <= mux_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.select    = sel_q;
    assign bus.mux_out   = mux_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
// Directed stimulus with hand-computed expectations queued per clock edge; an
// independent monitor pops one expectation after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    mux_arbiter_if bus ();

    mux_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string      name;
        logic [2:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       mux;
        bit         chk_mux;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [1:0] sel_of(input logic [2:0] g);
        case (g)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic compare(input string name, input logic [2:0] eg, input logic [1:0] es,
                           input logic ev, input logic em, input bit chk_mux);
        bit ok;
        ok = (bus.grant === eg) && (bus.select === es) && (bus.out_valid === ev) &&
             (!chk_mux || (bus.mux_out === em));
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got grant=%b select=%b valid=%b mux=%b, expected grant=%b select=%b valid=%b mux=%b",
                     name, bus.grant, bus.select, bus.out_valid, bus.mux_out, eg, es, ev, em);
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, queue
    // the outputs expected after it, then move to the following falling edge.
    task automatic step(input string name, input logic [2:0] r, input logic [2:0] d,
                        input logic [2:0] eg, input logic ev, input logic em);
        exp_t e;
        bus.req   = r;
        bus.din   = d;
        e.name    = name;
        e.grant   = eg;
        e.sel     = sel_of(eg);
        e.valid   = ev;
        e.mux     = em;
        e.chk_mux = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                compare(mon_e.name, mon_e.grant, mon_e.sel, mon_e.valid, mon_e.mux,
                        mon_e.chk_mux);
            end
        end
    end

    initial begin
        logic [2:0] din_f;
        logic [2:0] eg;
        logic       em;

        reset_n = 1'b0;
        bus.req = 3'b111;
        bus.din = 3'b000;
`ifdef MUX_ARBITER_LOCK_EN
        bus.lock = 3'b000;
`endif
        repeat (3) @(posedge clock);
        #2;
        compare("reset_hold", 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);

        @(negedge clock);
        reset_n = 1'b1;

        // All three requesting, MAX_HOLD=4: 4 cycles each, no idle gaps.
        din_f = 3'b101;
        for (int e = 1; e <= 14; e++) begin
            eg = 3'b001 << (((e - 1) / 4) % 3);
            em = (e >= 2) ? din_f[((e - 2) / 4) % 3] : 1'b0;
            step($sformatf("fair_e%0d", e), 3'b111, din_f, eg, (e >= 2), em);
        end

        // Owner 0 drops while 2 waits, then everyone drops.
        step("rel_to_2",   3'b100, 3'b100, 3'b100, 1'b1, 1'b0);
        step("rel_idle",   3'b000, 3'b100, 3'b000, 1'b1, 1'b1);
        step("idle_vlow",  3'b000, 3'b100, 3'b000, 1'b0, 1'b1);
        step("idle_hold",  3'b000, 3'b100, 3'b000, 1'b0, 1'b1);

        // Lone requester 1: held, counter saturates.
        step("single_gnt", 3'b010, 3'b010, 3'b010, 1'b0, 1'b1);
        step("single_d1",  3'b010, 3'b010, 3'b010, 1'b1, 1'b1);
        step("single_d2",  3'b010, 3'b010, 3'b010, 1'b1, 1'b1);
        step("single_d3",  3'b010, 3'b010, 3'b010, 1'b1, 1'b1);
        step("single_d4",  3'b010, 3'b000, 3'b010, 1'b1, 1'b0);
        step("single_d5",  3'b010, 3'b000, 3'b010, 1'b1, 1'b0);

        // Saturated counter: a newcomer takes over on the very next edge.
        step("sat_preempt", 3'b011, 3'b000, 3'b001, 1'b1, 1'b0);
        step("sat_after",   3'b011, 3'b000, 3'b001, 1'b1, 1'b0);

`ifdef MUX_ARBITER_LOCK_EN
        bus.lock = 3'b001;
        for (int k = 0; k < 10; k++) begin
            step($sformatf("lock_hold%0d", k), 3'b011, 3'b000, 3'b001, 1'b1, 1'b0);
        end
        bus.lock = 3'b000;
        step("lock_release", 3'b011, 3'b000, 3'b010, 1'b1, 1'b0);
`endif

        // Drain to idle, then start a burst for the asynchronous reset check.
        step("drain1", 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step("drain2", 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        step("burst1", 3'b001, 3'b111, 3'b001, 1'b0, 1'b0);
        step("burst2", 3'b001, 3'b111, 3'b001, 1'b1, 1'b1);
        step("burst3", 3'b001, 3'b111, 3'b001, 1'b1, 1'b1);

        #2;
        reset_n = 1'b0;
        #1;
        compare("async_reset", 3'b000, 2'b00, 1'b0, 1'b0, 1'b1);

        @(negedge clock);
        reset_n = 1'b1;
        step("post_rst1", 3'b111, 3'b111, 3'b001, 1'b0, 1'b0);
        step("post_rst2", 3'b111, 3'b111, 3'b001, 1'b1, 1'b1);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive cycles one requester holds the grant while another requester is pending; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  request per requester; req[0]=requester 0 (in1), req[1]=requester 1 (in2), req[2]=requester 2 (in3).
REQ-005 din  input  3  data bit per requester; din[i] is routed when requester i is granted.
REQ-006 lock  input  3  per-requester lock; present only when MUX_ARBITER_LOCK_EN is defined (see Configuration).
REQ-007 grant  output  3  registered one-hot grant, or all-zero when idle.
REQ-008 select  output  2  registered mux select: 2'b00 idle, 2'b01 requester 0, 2'b10 requester 1, 2'b11 requester 2.
REQ-009 mux_out  output  1  registered data from the granted requester.
REQ-010 out_valid  output  1  high when mux_out carries granted data.

Function
REQ-011 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant active).
REQ-012 IDLE->BUSY: on an edge with any req high, grant SHALL go to the first requester with req high, searching round-robin from (last_winner+1) mod 3.
REQ-013 Grant latency: a req sampled high at edge N in IDLE SHALL give grant/select valid after edge N.
REQ-014 mux_out SHALL equal din[g] sampled at the edge after grant g became valid; out_valid SHALL be high in that same cycle; result latency is 2 edges from req.
REQ-015 While in BUSY with the granted req high: the grant SHALL be held, and a hold counter SHALL increment each edge.
REQ-016 On the edge where the hold counter equals MAX_HOLD-1 and another req is high, the grant SHALL move directly to the next round-robin requester.
REQ-017 A handover SHALL take no idle cycle, and the hold counter SHALL reset to 0.
REQ-018 If no other req is high, the counter SHALL saturate at MAX_HOLD-1 and the grant SHALL be kept.
REQ-019 If the granted req drops: the grant SHALL move on that edge to the next round-robin pending requester, or go to IDLE if none is pending.
REQ-020 Simultaneous requests SHALL be resolved solely by the round-robin pointer; last_winner SHALL update on every new grant.
REQ-021 grant and select SHALL always be consistent, and grant SHALL never have more than one bit set.
REQ-022 When no grant is active, out_valid SHALL be 0 and mux_out SHALL hold its last value.

Reset
REQ-023 While reset_n is low: state=IDLE, grant=3'b000, select=2'b00, mux_out=0, out_valid=0, hold counter=0, last_winner=2 (so requester 0 wins first).
REQ-024 Reset asserted mid-grant SHALL clear all outputs immediately (asynchronously), without waiting for a clock edge.
REQ-025 After reset_n deasserts, the first grant SHALL occur no earlier than the first rising edge following the deassertion.

Configuration
REQ-026 Macro MUX_ARBITER_LOCK_EN defined: the lock port exists.
REQ-027 With MUX_ARBITER_LOCK_EN, while lock[g] and req[g] are high for granted requester g, the MAX_HOLD preemption SHALL be suppressed.
REQ-028 With MUX_ARBITER_LOCK_EN, a drop of req[g] SHALL still release the grant.
REQ-029 MUX_ARBITER_LOCK_EN undefined: no lock port, and preemption SHALL always apply.

Structure
REQ-030 A shared package mux_arb_pkg SHALL hold the state enum (IDLE, BUSY), select encodings (SEL_IDLE, SEL_REQ0, SEL_REQ1, SEL_REQ2), and the requester-count constant NUM_REQ=3.
REQ-031 The round-robin picker SHALL be one combinational sub-module, rr_pick: inputs req and last_winner; outputs one-hot next grant and a found flag.
REQ-032 The mux datapath SHALL be inline, not a separate instance.

Verification
REQ-033 Reset: hold reset_n low with req=3'b111 -> grant=000, select=00, out_valid=0; after release, first edge -> grant=001, select=01.
REQ-034 Single requester: req=3'b010, din=3'b010 -> grant=010 after edge 1; mux_out=1, out_valid=1 after edge 2; grant held while req stays high.
REQ-035 Fairness: req=3'b111 constant, MAX_HOLD=4 -> grant sequence 001x4, 010x4, 100x4, 001..., with no idle cycle between grants.
REQ-036 Release: grant=001 and req drops to 3'b100 -> next edge grant=100, select=11; then req=000 -> IDLE, out_valid=0 one edge later.
REQ-037 Lock (MUX_ARBITER_LOCK_EN): req=3'b011, lock=3'b001 -> grant stays 001 for 10 cycles; lock=0 -> grant=010 within MAX_HOLD edges.
REQ-038 Async reset: assert reset_n mid-burst between clock edges -> all outputs 0 before the next edge.
